// File: rtl/mem_responder.sv
// Memory-side responder for CPU load/store traffic: one request in flight,
// fixed access latency, big-endian byte/half/word lanes, fault reporting.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_p0;
    state_t             state_nxt;
    logic [3:0]         cnt_p0;
    logic [IDX_W-1:0]   idx_p0;
    logic [1:0]         off_p0;
    logic [1:0]         size_p0;
    logic               write_p0;
    logic [31:0]        wdata_p0;
    logic               err_p0;
    logic               req_err;
    logic               accept;
    logic               access;
    logic [31:0]        rd_word;
    logic [31:0]        mem [DEPTH_WORDS];

    // Insert right-aligned store data into the addressed big-endian lanes.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = old_word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[31:24] = wd[7:0];
                    2'd1:    r[23:16] = wd[7:0];
                    2'd2:    r[15:8]  = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[15:0]  = wd[15:0];
                else        r[31:16] = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed lanes down to bit 0, zero-filling the upper bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        logic [31:0] r;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r = {24'h0, word[31:24]};
                    2'd1:    r = {24'h0, word[23:16]};
                    2'd2:    r = {24'h0, word[15:8]};
                    default: r = {24'h0, word[7:0]};
                endcase
            end
            2'b01:   r = off[1] ? {16'h0, word[15:0]} : {16'h0, word[31:16]};
            default: r = word;
        endcase
        return r;
    endfunction

    assign accept  = (state_p0 == IDLE) && req_valid;
    assign access  = (state_p0 == WAIT) && (cnt_p0 == 4'd0) && !reset;
    assign rd_word = mem[idx_p0];

    // Fault classification of the incoming request (size, alignment, range).
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b11:   req_err = 1'b1;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b0;
        endcase
        if (req_addr >= BYTE_LIMIT) req_err = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_p0 <= IDLE;
        else       state_p0 <= state_nxt;
    end

    // FSM next state plus handshake/response strobes.
    always_comb begin
        state_nxt = state_p0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_p0)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt_p0 == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   cnt_p0 <= 4'd0;
        else if (accept)                             cnt_p0 <= CNT_INIT;
        else if (state_p0 == WAIT && cnt_p0 != 4'd0) cnt_p0 <= cnt_p0 - 4'd1;
    end

    // Request capture stage; only the word index and lane offset are kept.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0   <= req_addr[IDX_W+1:2];
            off_p0   <= req_addr[1:0];
            size_p0  <= req_size;
            write_p0 <= req_write;
            wdata_p0 <= req_wdata;
            err_p0   <= req_err;
        end
    end

    // RAM write at the access edge; faulted or aborted stores never land.
    always_ff @(posedge clk) begin
        if (access && write_p0 && !err_p0)
            mem[idx_p0] <= lane_merge(rd_word, wdata_p0, size_p0, off_p0);
    end

    // Response data/error, held until the next access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
        end else if (access) begin
            rsp_error <= err_p0;
            rsp_rdata <= (err_p0 || write_p0) ? 32'h0 : lane_extract(rd_word, size_p0, off_p0);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (LATENCY=2 main instance, LATENCY=1 side instance).
module tb_mem_responder;

    localparam int L     = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;

    logic        l1_valid, l1_ready, l1_write;
    logic [1:0]  l1_size;
    logic [31:0] l1_addr, l1_wdata;
    logic        l1_rsp_valid, l1_error;
    logic [31:0] l1_rdata;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(l1_valid), .req_ready(l1_ready), .req_write(l1_write),
        .req_size(l1_size), .req_addr(l1_addr), .req_wdata(l1_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_rdata(l1_rdata), .rsp_error(l1_error)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  bmem [0:4*DEPTH-1];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0;
    int          acc_log[$];
    logic [31:0] last_rdata;
    logic        last_err;
    int          l1_acc_cnt = 0, l1_acc_cyc = 0, l1_rsp_cnt = 0;
    int          l1_acc_log[$];
    logic [31:0] l1_last_rdata;
    logic        l1_last_err;

    // Reference model over a flat byte array, big-endian.
    function automatic exp_t predict(input logic wr, input logic [1:0] sz,
                                     input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   ia;
        ia = int'(a[11:0]);
        e.wr = wr; e.size = sz; e.addr = a; e.wdata = wd;
        e.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
                || (a >= 32'(4 * DEPTH));
        e.rdata = 32'h0;
        if (!e.err && !wr) begin
            case (sz)
                2'b00:   e.rdata = {24'h0, bmem[ia]};
                2'b01:   e.rdata = {16'h0, bmem[ia], bmem[ia+1]};
                default: e.rdata = {bmem[ia], bmem[ia+1], bmem[ia+2], bmem[ia+3]};
            endcase
        end
        return e;
    endfunction

    function automatic void apply_write(input exp_t e);
        int ia;
        ia = int'(e.addr[11:0]);
        if (e.wr && !e.err) begin
            case (e.size)
                2'b00: bmem[ia] = e.wdata[7:0];
                2'b01: begin bmem[ia] = e.wdata[15:8]; bmem[ia+1] = e.wdata[7:0]; end
                default: begin
                    bmem[ia]   = e.wdata[31:24]; bmem[ia+1] = e.wdata[23:16];
                    bmem[ia+2] = e.wdata[15:8];  bmem[ia+3] = e.wdata[7:0];
                end
            endcase
        end
    endfunction

    // Acceptance monitor: pushes expected responses; reset discards pending ones.
    always @(posedge clk) begin
        if (reset) begin
            sbq.delete();
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                acc_cnt++;
                acc_log.push_back(cyc);
                sbq.push_back(predict(req_write, req_size, req_addr, req_wdata));
            end
            if (l1_valid && l1_ready) begin
                l1_acc_cyc = cyc;
                l1_acc_cnt++;
                l1_acc_log.push_back(cyc);
            end
        end
        cyc++;
    end

    // Response monitor: latency, ready exclusion and scoreboard comparison.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid) begin
            checks++;
            if (cyc - acc_cyc != L + 1) begin
                errors++;
                $display("FAIL rsp_latency got=%0d want=%0d", cyc - acc_cyc - 1, L);
            end
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_during_rsp got=%b want=0", req_ready);
            end
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp rdata=%h err=%b want=no response", rsp_rdata, rsp_error);
            end else begin
                e = sbq.pop_front();
                if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
                    errors++;
                    $display("FAIL sb_rsp addr=%h got=%h/%b want=%h/%b",
                             e.addr, rsp_rdata, rsp_error, e.rdata, e.err);
                end
                apply_write(e);
            end
            last_rdata = rsp_rdata;
            last_err   = rsp_error;
            rsp_cnt++;
        end
        if (!reset && l1_rsp_valid) begin
            checks++;
            if (cyc - l1_acc_cyc != 2) begin
                errors++;
                $display("FAIL l1_latency got=%0d want=1", cyc - l1_acc_cyc - 1);
            end
            l1_last_rdata = l1_rdata;
            l1_last_err   = l1_error;
            l1_rsp_cnt++;
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        int a0;
        a0 = acc_cnt;
        req_write = wr; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == a0; i++) @(negedge clk);
        req_valid = 1'b0;
        if (acc_cnt == a0) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h got=no accept want=accept", a);
        end
    endtask

    task automatic wait_rsp(input int r0);
        for (int i = 0; i < 20 && rsp_cnt == r0; i++) @(negedge clk);
        if (rsp_cnt == r0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout got=no rsp want=rsp");
        end
    endtask

    task automatic xfer(input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        int r0;
        r0 = rsp_cnt;
        issue(wr, sz, a, wd);
        wait_rsp(r0);
    endtask

    task automatic test_reset();
        req_valid = 0; req_write = 0; req_size = 0; req_addr = 0; req_wdata = 0;
        l1_valid = 0; l1_write = 0; l1_size = 0; l1_addr = 0; l1_wdata = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%b/%h/%b want=1/0/00000000/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_error);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got=%b/%b want=1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_word();
        int r0, lo;
        r0 = rsp_cnt;
        issue(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        lo = 0;
        for (int i = 0; i < 10 && req_ready === 1'b0; i++) begin
            lo++;
            @(negedge clk);
        end
        checks++;
        if (lo != L + 1) begin
            errors++;
            $display("FAIL ready_low_cycles got=%0d want=%0d", lo, L + 1);
        end
        checks++;
        if (rsp_cnt != r0 + 1 || last_err !== 1'b0 || last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL word_store_rsp got=%0d/%h/%b want=1/00000000/0", rsp_cnt - r0, last_rdata, last_err);
        end
        xfer(1'b0, 2'b10, 32'h10, 32'h0);
        checks++;
        if (last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin
            errors++;
            $display("FAIL word_load got=%h/%b want=deadbeef/0", last_rdata, last_err);
        end
    endtask

    task automatic test_byte();
        xfer(1'b1, 2'b00, 32'h11, 32'h000000AA);
        xfer(1'b0, 2'b10, 32'h10, 32'h0);
        checks++;
        if (last_rdata !== 32'hDEAABEEF || last_err !== 1'b0) begin
            errors++;
            $display("FAIL byte_store_lane got=%h/%b want=deaabeef/0", last_rdata, last_err);
        end
        xfer(1'b0, 2'b00, 32'h13, 32'h0);
        checks++;
        if (last_rdata !== 32'h000000EF || last_err !== 1'b0) begin
            errors++;
            $display("FAIL byte_load got=%h/%b want=000000ef/0", last_rdata, last_err);
        end
    endtask

    task automatic test_half_err();
        xfer(1'b0, 2'b01, 32'h12, 32'h0);
        checks++;
        if (last_rdata !== 32'h0000BEEF || last_err !== 1'b0) begin
            errors++;
            $display("FAIL half_load got=%h/%b want=0000beef/0", last_rdata, last_err);
        end
        xfer(1'b1, 2'b01, 32'h10, 32'hFFFFC0DE);
        xfer(1'b0, 2'b10, 32'h10, 32'h0);
        checks++;
        if (last_rdata !== 32'hC0DEBEEF) begin
            errors++;
            $display("FAIL half_store_lane got=%h want=c0debeef", last_rdata);
        end
        xfer(1'b0, 2'b01, 32'h13, 32'h0);
        checks++;
        if (last_rdata !== 32'h0 || last_err !== 1'b1) begin
            errors++;
            $display("FAIL half_misalign got=%h/%b want=00000000/1", last_rdata, last_err);
        end
        xfer(1'b0, 2'b10, 32'h12, 32'h0);
        checks++;
        if (last_rdata !== 32'h0 || last_err !== 1'b1) begin
            errors++;
            $display("FAIL word_misalign got=%h/%b want=00000000/1", last_rdata, last_err);
        end
        xfer(1'b0, 2'b11, 32'h10, 32'h0);
        checks++;
        if (last_rdata !== 32'h0 || last_err !== 1'b1) begin
            errors++;
            $display("FAIL size_reserved got=%h/%b want=00000000/1", last_rdata, last_err);
        end
    endtask

    task automatic test_range();
        xfer(1'b1, 2'b10, 32'h0, 32'h11223344);
        xfer(1'b1, 2'b10, 32'h400, 32'h12345678);
        checks++;
        if (last_rdata !== 32'h0 || last_err !== 1'b1) begin
            errors++;
            $display("FAIL range_store got=%h/%b want=00000000/1", last_rdata, last_err);
        end
        xfer(1'b0, 2'b10, 32'h0, 32'h0);
        checks++;
        if (last_rdata !== 32'h11223344 || last_err !== 1'b0) begin
            errors++;
            $display("FAIL range_no_alias got=%h/%b want=11223344/0", last_rdata, last_err);
        end
        xfer(1'b1, 2'b10, 32'h3FC, 32'h55667788);
        xfer(1'b0, 2'b10, 32'h3FC, 32'h0);
        checks++;
        if (last_rdata !== 32'h55667788 || last_err !== 1'b0) begin
            errors++;
            $display("FAIL top_word got=%h/%b want=55667788/0", last_rdata, last_err);
        end
        xfer(1'b0, 2'b00, 32'h80000000, 32'h0);
        checks++;
        if (last_err !== 1'b1) begin
            errors++;
            $display("FAIL range_high_bit got=%b want=1", last_err);
        end
    endtask

    task automatic test_abort();
        int r0;
        xfer(1'b1, 2'b10, 32'h20, 32'h01020304);
        r0 = rsp_cnt;
        issue(1'b1, 2'b10, 32'h20, 32'hCAFEF00D);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_cnt != r0) begin
            errors++;
            $display("FAIL abort_rsp got=%0d want=0", rsp_cnt - r0);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got=%b want=1", req_ready);
        end
        xfer(1'b0, 2'b10, 32'h20, 32'h0);
        checks++;
        if (last_rdata !== 32'h01020304 || last_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write got=%h/%b want=01020304/0", last_rdata, last_err);
        end
    endtask

    task automatic test_back_to_back();
        int a0, r0, n;
        repeat (2) @(negedge clk);
        a0 = acc_log.size();
        r0 = rsp_cnt;
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hA5A5A5A5;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_log.size() > a0) begin
                req_addr = 32'h34; req_wdata = 32'h5A5A5A5A;
            end
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        n = acc_log.size() - a0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL b2b_accepts got=%0d want=5", n);
        end
        for (int i = a0 + 1; i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i] - acc_log[i-1] != L + 2) begin
                errors++;
                $display("FAIL b2b_gap got=%0d want=%0d", acc_log[i] - acc_log[i-1], L + 2);
            end
        end
        checks++;
        if (rsp_cnt - r0 != n) begin
            errors++;
            $display("FAIL b2b_rsps got=%0d want=%0d", rsp_cnt - r0, n);
        end
        xfer(1'b0, 2'b10, 32'h30, 32'h0);
        checks++;
        if (last_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL b2b_first got=%h want=a5a5a5a5", last_rdata);
        end
        xfer(1'b0, 2'b10, 32'h34, 32'h0);
        checks++;
        if (last_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL b2b_second got=%h want=5a5a5a5a", last_rdata);
        end
    endtask

    task automatic l1_load(input logic [31:0] a, output logic [31:0] d, output logic e);
        int a0, r0;
        a0 = l1_acc_cnt;
        r0 = l1_rsp_cnt;
        l1_write = 1'b0; l1_size = 2'b10; l1_addr = a; l1_valid = 1'b1;
        for (int i = 0; i < 20 && l1_acc_cnt == a0; i++) @(negedge clk);
        l1_valid = 1'b0;
        for (int i = 0; i < 20 && l1_rsp_cnt == r0; i++) @(negedge clk);
        if (l1_rsp_cnt == r0) begin
            checks++; errors++;
            $display("FAIL l1_load_timeout addr=%h got=no rsp want=rsp", a);
        end
        d = l1_last_rdata;
        e = l1_last_err;
    endtask

    task automatic test_latency1();
        int a0, r0, n;
        logic [31:0] d;
        logic        e;
        a0 = l1_acc_log.size();
        r0 = l1_rsp_cnt;
        l1_write = 1'b1; l1_size = 2'b10; l1_addr = 32'h8; l1_wdata = 32'h0BADF00D;
        l1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (l1_acc_log.size() > a0) begin
                l1_addr = 32'hC; l1_wdata = 32'h600DCAFE;
            end
        end
        l1_valid = 1'b0;
        repeat (4) @(negedge clk);
        n = l1_acc_log.size() - a0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL l1_accepts got=%0d want=4", n);
        end
        for (int i = a0 + 1; i < l1_acc_log.size(); i++) begin
            checks++;
            if (l1_acc_log[i] - l1_acc_log[i-1] != 3) begin
                errors++;
                $display("FAIL l1_gap got=%0d want=3", l1_acc_log[i] - l1_acc_log[i-1]);
            end
        end
        checks++;
        if (l1_rsp_cnt - r0 != n) begin
            errors++;
            $display("FAIL l1_rsps got=%0d want=%0d", l1_rsp_cnt - r0, n);
        end
        l1_load(32'h8, d, e);
        checks++;
        if (d !== 32'h0BADF00D || e !== 1'b0) begin
            errors++;
            $display("FAIL l1_first got=%h/%b want=0badf00d/0", d, e);
        end
        l1_load(32'hC, d, e);
        checks++;
        if (d !== 32'h600DCAFE || e !== 1'b0) begin
            errors++;
            $display("FAIL l1_second got=%h/%b want=600dcafe/0", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_err();
        test_range();
        test_abort();
        test_back_to_back();
        test_latency1();
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d want=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store traffic. The CPU datapath is the initiator; this block is the target.
- Accepts one request at a time through a valid/ready handshake and models a configurable access latency.
- Handles byte, halfword and word accesses to a big-endian, byte-addressed RAM.
- Returns read data, or an error flag that the control FSM turns into an exception (the EPC path).

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM. The valid byte range is 0 to 4*DEPTH_WORDS-1.
- LATENCY, 2, cycles from request acceptance to response. Legal range is 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load data, zero-extended and right-aligned
- rsp_error  out  1  request faulted; valid only while rsp_valid is high

Behaviour:
- Reset values:
  - state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0.
  - RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid is high at a rising edge N, the request is accepted: latch addr/size/write/wdata, compute the error flag, load the counter with LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each edge. At the edge where the counter is 0, perform the access, register the outputs, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0. The next edge returns to IDLE.
- Timing:
  - rsp_valid is high during the cycle following edge N+LATENCY.
  - req_ready returns high after edge N+LATENCY+1.
  - Maximum throughput is one request per LATENCY+2 cycles.
  - req_valid and other request inputs are ignored while not in IDLE. They are never accepted twice.
- Error conditions, evaluated at acceptance:
  - req_size=11.
  - half with addr[0]!=0.
  - word with addr[1:0]!=0.
  - addr >= 4*DEPTH_WORDS (all 32 bits compared).
- On error:
  - rsp_error=1 and rsp_rdata=0.
  - No RAM write.
- Byte lanes (big-endian), for word index addr/4:
  - byte offset 0 maps to bits [31:24], offset 1 to [23:16], offset 2 to [15:8], offset 3 to [7:0].
  - half offset 0 maps to [31:16], offset 2 to [15:0].
- Store:
  - Only the addressed lanes are written, from the low bits of req_wdata. Other lanes are unchanged.
  - rsp_rdata=0 on a store response.
- Load:
  - The selected lanes are shifted down to bit 0 and upper bits are zero-filled. Sign extension is the CPU's job.
- rsp_rdata and rsp_error hold their last registered values after the RESP cycle until the next response is produced.
- Reset asserted mid-operation (WAIT or RESP):
  - Return immediately to IDLE.
  - The pending store is discarded with no partial write.
  - No rsp_valid is produced for the aborted request.
- A RAM write and a RAM read never overlap, because only one request is in flight. Read-during-write does not occur.

Test Plan:
1. Word store 0xDEADBEEF to 0x10, then word load 0x10.
   - Required: rsp_valid exactly LATENCY edges after each acceptance, rdata=0xDEADBEEF, error=0, req_ready low for LATENCY+1 cycles.
2. Byte store 0x000000AA to 0x11, then word load 0x10 -> 0xDEAABEEF. Byte load 0x13 -> 0x000000EF.
3. Half load 0x12 -> 0x0000BEEF.
   - Half load 0x13 -> error=1, rdata=0.
   - Word load 0x12 -> error=1.
   - req_size=11 -> error=1.
4. Word store 0x12345678 to 0x400 (DEPTH_WORDS=256) -> error=1. A following word load of 0x0 returns its unchanged value.
5. Word store 0xCAFEF00D to 0x20 accepted, then reset pulsed one cycle later.
   - Required: no rsp_valid for the aborted store, req_ready=1 after release, word load 0x20 returns the prior contents.
6. req_valid held high for 20 cycles with LATENCY=2 and two different stores queued.
   - Required: exactly one acceptance per 4 cycles, no duplicate acceptance during WAIT/RESP, both writes land once.
   - Repeat with LATENCY=1: rsp_valid appears the cycle after the next edge following acceptance.
